rf_banked: RTL and testbench
============================

RF_BANKED -- requirements
Module: rf_banked

Interface
REQ-001 SHALL have parameter DW, default 32, data width.
REQ-002 SHALL have parameter NREG, default 32, registers per bank (power of 2); AW = log2(NREG).
REQ-003 SHALL have parameter NRD, default 2, combinational read ports.
REQ-004 SHALL have parameter NBANK, default 2, shadow banks (power of 2, >=2); BW = log2(NBANK).
REQ-005 SHALL have parameter GP_IDX, default 28, and GP_INIT, default 32'h0000_1800; this is the gp reset value.
REQ-006 SHALL have port clk, input, 1, the clock; rising edge is active.
REQ-007 SHALL have port rst, input, 1, the reset; reset is asynchronous and active-low.
REQ-008 SHALL have port we, input, 1, the write enable.
REQ-009 SHALL have port wa, input, AW, the write address.
REQ-010 SHALL have port din, input, DW, the write data.
REQ-011 SHALL have port ra, input, NRD*AW, the packed read addresses; port k occupies [k*AW +: AW].
REQ-012 SHALL have port dout, output, NRD*DW, the packed read data.
REQ-013 SHALL have port int_entry, input, 1, an interrupt-entry pulse that pushes the bank.
REQ-014 SHALL have port eret, input, 1, an exception-return pulse that pops the bank.
REQ-015 SHALL have port bank, output, BW, the current bank.
REQ-016 SHALL have port bank_err, output, 1, a sticky overflow/underflow flag.
REQ-017 SHALL have ports dbg_ra, input, AW, and dbg_dout, output, DW; together they form a debug read of the current bank.

Function
REQ-018 SHALL update register wa of the current bank with din at the rising clk edge when we=1 and wa!=0.
REQ-019 SHALL read register 0 as 0 in every bank, on every port; writes to register 0 have no effect.
REQ-020 SHALL return register ra[k] of the current bank combinationally on each dout port k; dbg_dout behaves the same way.
REQ-021 SHALL apply a write to the bank that is current before the edge, when a write and a bank change occur on the same edge.
REQ-022 SHALL change bank only at the rising edge, as follows:
- int_entry only, bank<NBANK-1: bank increments.
- int_entry only, bank=NBANK-1: bank unchanged; bank_err set.
- eret only, bank>0: bank decrements.
- eret only, bank=0: bank unchanged; bank_err set.
- int_entry and eret together: bank unchanged; no error.
REQ-023 SHALL keep bank_err set until reset once it is set.
REQ-024 SHALL share register GP_IDX across all banks; writes to it and reads of it address a single physical register.
REQ-025 SHALL NOT copy or clear bank contents on a bank switch.
REQ-026 SHALL leave the read latency at zero cycles; write-to-read latency is one edge unless RF_BYPASS_EN is defined.

Reset
REQ-027 SHALL, while rst=0, asynchronously force the following:
- bank = 0 and bank_err = 0.
- All registers in all banks = 0, except GP_IDX = GP_INIT.
REQ-028 SHALL make dout and dbg_dout reflect the reset contents while in reset.
REQ-029 SHALL discard any write, int_entry or eret pending when reset asserts mid-cycle.
REQ-030 SHALL ignore we, int_entry and eret on the first edge after rst rises only if rst deasserts less than setup before that edge; otherwise that edge operates normally.

Configuration
REQ-031 SHALL, when macro RF_BYPASS_EN is defined, drive dout[k] = din combinationally when we=1, wa!=0, wa=ra[k] and the write targets the current bank. dbg_dout bypasses in the same way.
REQ-032 SHALL, without RF_BYPASS_EN, return the stored value on dout until the write edge.

Structure
REQ-033 SHALL place DW/AW defaults, GP_IDX, GP_INIT and the bank-change encoding (HOLD/PUSH/POP) in the shared package rf_pkg.
REQ-034 SHALL implement the bank pointer and bank_err logic in the sub-module rf_bank_ctl (clk, rst, int_entry, eret -> bank, bank_err).
REQ-035 SHALL keep the storage array and read muxes in rf_banked; the RTL is 120-400 lines total.

Verification
REQ-036 SHALL have a reset check: rst=0 then 1; r28 reads 32'h0000_1800, r5 reads 0, bank=0, bank_err=0.
REQ-037 SHALL have a write/read check:
- Write r7=32'hDEAD_BEEF on bank 0.
- Pulse int_entry; r7 reads 0 in bank 1.
- Write r7=32'h1234 in bank 1.
- Pulse eret; r7 reads 32'hDEAD_BEEF.
REQ-038 SHALL have a shared-gp check: in bank 1 write r28=32'h2000; after eret, r28 reads 32'h2000.
REQ-039 SHALL have a boundary check:
- From bank 0, eret sets bank_err=1.
- int_entry twice with NBANK=2 leaves bank=1 and bank_err=1.
- int_entry and eret together leave the bank unchanged.
REQ-040 SHALL have a bypass check:
- we=1, wa=3, din=32'h55 with ra0=3.
- With RF_BYPASS_EN, dout0=32'h55 in the same cycle.
- Without it, dout0=old value until the edge.
- A write to r0 returns 0 in both builds.
REQ-041 SHALL have a reset-mid-operation check: assert rst between int_entry and the edge; bank=0 and the write is discarded.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared defaults and bank-change encoding for the banked register file.
// Optional macro RF_BYPASS_EN is consumed by rf_banked.
package rf_pkg;

    localparam int DW_DEFAULT   = 32;
    localparam int NREG_DEFAULT = 32;
    localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);
    localparam int GP_IDX_DEFAULT = 28;
    localparam logic [31:0] GP_INIT_DEFAULT = 32'h0000_1800;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        PUSH = 2'd1,
        POP  = 2'd2
    } bank_op_t;

endpackage

// File: rtl/rf_banked_if.sv
// Signal bundle for the banked register file: write, read,
// bank-switch and debug-read lines.
interface rf_banked_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2,
    parameter int BW  = 1
);
    logic              we;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     din;
    logic [NRD*AW-1:0] ra;
    logic [NRD*DW-1:0] dout;
    logic              int_entry;
    logic              eret;
    logic [BW-1:0]     bank;
    logic              bank_err;
    logic [AW-1:0]     dbg_ra;
    logic [DW-1:0]     dbg_dout;

    modport master (
        output we, wa, din, ra, int_entry, eret, dbg_ra,
        input  dout, bank, bank_err, dbg_dout
    );

    modport slave (
        input  we, wa, din, ra, int_entry, eret, dbg_ra,
        output dout, bank, bank_err, dbg_dout
    );
endinterface

// File: rtl/rf_bank_ctl.sv
// Shadow-bank pointer: push on interrupt entry, pop on eret,
// sticky error on overflow/underflow.
module rf_bank_ctl
    import rf_pkg::*;
#(
    parameter int NBANK = 2,
    localparam int BW = $clog2(NBANK)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          int_entry,
    input  logic          eret,
    output logic [BW-1:0] bank,
    output logic          bank_err
);

    bank_op_t op;

    // Simultaneous push and pop cancel out.
    always_comb begin
        op = HOLD;
        unique case ({int_entry, eret})
            2'b10:   op = PUSH;
            2'b01:   op = POP;
            default: op = HOLD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bank     <= '0;
            bank_err <= 1'b0;
        end else begin
            unique case (op)
                PUSH: begin
                    if (bank == BW'(NBANK - 1))
                        bank_err <= 1'b1;
                    else
                        bank <= bank + BW'(1);
                end
                POP: begin
                    if (bank == '0)
                        bank_err <= 1'b1;
                    else
                        bank <= bank - BW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/rf_banked.sv
// Banked register file with shared gp and combinational reads.
// Define RF_BYPASS_EN to forward same-cycle writes onto read ports.
module rf_banked
    import rf_pkg::*;
#(
    parameter int DW     = DW_DEFAULT,
    parameter int NREG   = NREG_DEFAULT,
    parameter int NRD    = 2,
    parameter int NBANK  = 2,
    parameter int GP_IDX = GP_IDX_DEFAULT,
    parameter logic [31:0] GP_INIT = GP_INIT_DEFAULT,
    localparam int AW = $clog2(NREG),
    localparam int BW = $clog2(NBANK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     wa,
    input  logic [DW-1:0]     din,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*DW-1:0] dout,
    input  logic              int_entry,
    input  logic              eret,
    output logic [BW-1:0]     bank,
    output logic              bank_err,
    input  logic [AW-1:0]     dbg_ra,
    output logic [DW-1:0]     dbg_dout
);

    localparam logic [AW-1:0] GP_A = AW'(GP_IDX);

    logic [DW-1:0] regs [NBANK][NREG];
    logic [DW-1:0] gp;

    rf_bank_ctl #(.NBANK(NBANK)) u_ctl (
        .clk       (clk),
        .rst       (rst),
        .int_entry (int_entry),
        .eret      (eret),
        .bank      (bank),
        .bank_err  (bank_err)
    );

    // Write uses the pre-edge bank, so a write racing a switch lands in the old bank.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gp <= DW'(GP_INIT);
            for (int b = 0; b < NBANK; b++)
                for (int r = 0; r < NREG; r++)
                    regs[b][r] <= '0;
        end else if (we && wa != '0) begin
            if (wa == GP_A)
                gp <= din;
            else
                regs[bank][wa] <= din;
        end
    end

    function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        if (a == '0)
            v = '0;
        else if (a == GP_A)
            v = gp;
        else
            v = regs[bank][a];
`ifdef RF_BYPASS_EN
        if (we && wa != '0 && wa == a)
            v = din;
`endif
        return v;
    endfunction

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        assign dout[k*DW +: DW] = rd(ra[k*AW +: AW]);
    end

    assign dbg_dout = rd(dbg_ra);

endmodule

// File: tb/tb_rf_banked.sv
// Directed self-checking bench for rf_banked (default parameters).
// Bypass expectations follow RF_BYPASS_EN.
module tb_rf_banked;

    logic clk;
    logic rst;
    int vectors;
    int miscompares;

    rf_banked_if #(.DW(32), .AW(5), .NRD(2), .BW(1)) bus ();

    rf_banked dut (
        .clk       (clk),
        .rst       (rst),
        .we        (bus.we),
        .wa        (bus.wa),
        .din       (bus.din),
        .ra        (bus.ra),
        .dout      (bus.dout),
        .int_entry (bus.int_entry),
        .eret      (bus.eret),
        .bank      (bus.bank),
        .bank_err  (bus.bank_err),
        .dbg_ra    (bus.dbg_ra),
        .dbg_dout  (bus.dbg_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.we = 1'b1; bus.wa = a; bus.din = d;
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic pulse(input logic i, input logic e);
        @(negedge clk);
        bus.int_entry = i; bus.eret = e;
        @(negedge clk);
        bus.int_entry = 1'b0; bus.eret = 1'b0;
    endtask

    task automatic rd0(input logic [4:0] a, output logic [31:0] d);
        bus.ra[4:0] = a;
        #1;
        d = bus.dout[31:0];
    endtask

    task automatic rd1(input logic [4:0] a, output logic [31:0] d);
        bus.ra[9:5] = a;
        #1;
        d = bus.dout[63:32];
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        bus.dbg_ra = 5'd28;
        #1;
        vectors++;
        if (bus.dbg_dout !== 32'h0000_1800) begin
            miscompares++;
            $display("FAIL rst_dbg_gp_in_reset: got %h want %h", bus.dbg_dout, 32'h0000_1800);
        end
        @(negedge clk);
        rst = 1'b1;
        rd0(5'd28, v);
        vectors++;
        if (v !== 32'h0000_1800) begin
            miscompares++;
            $display("FAIL rst_r28: got %h want %h", v, 32'h0000_1800);
        end
        rd1(5'd5, v);
        vectors++;
        if (v !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_r5: got %h want %h", v, 32'h0);
        end
        vectors++;
        if (bus.bank !== 1'b0 || bus.bank_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_bank: got bank=%b err=%b want 0 0", bus.bank, bus.bank_err);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] v;
        wr(5'd7, 32'hDEAD_BEEF);
        rd0(5'd7, v);
        vectors++;
        if (v !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL wr_r7_b0: got %h want %h", v, 32'hDEAD_BEEF);
        end
        pulse(1'b1, 1'b0);
        rd0(5'd7, v);
        vectors++;
        if (bus.bank !== 1'b1 || v !== 32'h0) begin
            miscompares++;
            $display("FAIL r7_b1_empty: got bank=%b r7=%h want 1 %h", bus.bank, v, 32'h0);
        end
        wr(5'd7, 32'h0000_1234);
        bus.dbg_ra = 5'd7;
        #1;
        vectors++;
        if (bus.dbg_dout !== 32'h0000_1234) begin
            miscompares++;
            $display("FAIL dbg_r7_b1: got %h want %h", bus.dbg_dout, 32'h0000_1234);
        end
        pulse(1'b0, 1'b1);
        rd1(5'd7, v);
        vectors++;
        if (bus.bank !== 1'b0 || v !== 32'hDEAD_BEEF) begin
            miscompares++;
            $display("FAIL r7_after_eret: got bank=%b r7=%h want 0 %h", bus.bank, v, 32'hDEAD_BEEF);
        end
    endtask

    task automatic test_shared_gp();
        logic [31:0] v;
        pulse(1'b1, 1'b0);
        wr(5'd28, 32'h0000_2000);
        pulse(1'b0, 1'b1);
        rd0(5'd28, v);
        vectors++;
        if (v !== 32'h0000_2000) begin
            miscompares++;
            $display("FAIL gp_shared: got %h want %h", v, 32'h0000_2000);
        end
    endtask

    task automatic test_zero();
        logic [31:0] v;
        wr(5'd0, 32'hFFFF_FFFF);
        rd0(5'd0, v);
        vectors++;
        if (v !== 32'h0) begin
            miscompares++;
            $display("FAIL r0_zero: got %h want %h", v, 32'h0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        @(negedge clk);
        bus.we = 1'b1; bus.wa = 5'd9; bus.din = 32'h0000_AAAA;
        bus.int_entry = 1'b1;
        @(negedge clk);
        bus.we = 1'b1; bus.wa = 5'd10; bus.din = 32'h0000_BBBB;
        bus.int_entry = 1'b0;
        @(negedge clk);
        bus.we = 1'b0;
        rd0(5'd9, v);
        vectors++;
        if (bus.bank !== 1'b1 || v !== 32'h0) begin
            miscompares++;
            $display("FAIL race_b1_r9: got bank=%b r9=%h want 1 %h", bus.bank, v, 32'h0);
        end
        rd1(5'd10, v);
        vectors++;
        if (v !== 32'h0000_BBBB) begin
            miscompares++;
            $display("FAIL b2b_r10_b1: got %h want %h", v, 32'h0000_BBBB);
        end
        pulse(1'b0, 1'b1);
        rd0(5'd9, v);
        vectors++;
        if (v !== 32'h0000_AAAA) begin
            miscompares++;
            $display("FAIL race_b0_r9: got %h want %h", v, 32'h0000_AAAA);
        end
    endtask

    task automatic test_boundary();
        apply_reset();
        pulse(1'b0, 1'b1);
        #1;
        vectors++;
        if (bus.bank !== 1'b0 || bus.bank_err !== 1'b1) begin
            miscompares++;
            $display("FAIL underflow: got bank=%b err=%b want 0 1", bus.bank, bus.bank_err);
        end
        apply_reset();
        pulse(1'b1, 1'b0);
        #1;
        vectors++;
        if (bus.bank !== 1'b1 || bus.bank_err !== 1'b0) begin
            miscompares++;
            $display("FAIL push_once: got bank=%b err=%b want 1 0", bus.bank, bus.bank_err);
        end
        pulse(1'b1, 1'b0);
        #1;
        vectors++;
        if (bus.bank !== 1'b1 || bus.bank_err !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow: got bank=%b err=%b want 1 1", bus.bank, bus.bank_err);
        end
        apply_reset();
        pulse(1'b1, 1'b1);
        #1;
        vectors++;
        if (bus.bank !== 1'b0 || bus.bank_err !== 1'b0) begin
            miscompares++;
            $display("FAIL both_b0: got bank=%b err=%b want 0 0", bus.bank, bus.bank_err);
        end
        pulse(1'b1, 1'b0);
        pulse(1'b1, 1'b1);
        #1;
        vectors++;
        if (bus.bank !== 1'b1 || bus.bank_err !== 1'b0) begin
            miscompares++;
            $display("FAIL both_b1: got bank=%b err=%b want 1 0", bus.bank, bus.bank_err);
        end
        pulse(1'b0, 1'b1);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
        #1;
        vectors++;
        if (bus.bank !== 1'b1 || bus.bank_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: got bank=%b err=%b want 1 1", bus.bank, bus.bank_err);
        end
        apply_reset();
    endtask

    task automatic test_bypass();
        logic [31:0] v;
        logic [31:0] exp_same;
        wr(5'd3, 32'h0000_0011);
`ifdef RF_BYPASS_EN
        exp_same = 32'h0000_0055;
`else
        exp_same = 32'h0000_0011;
`endif
        @(negedge clk);
        bus.we = 1'b1; bus.wa = 5'd3; bus.din = 32'h0000_0055;
        bus.dbg_ra = 5'd3;
        rd0(5'd3, v);
        vectors++;
        if (v !== exp_same) begin
            miscompares++;
            $display("FAIL byp_same_cycle: got %h want %h", v, exp_same);
        end
        vectors++;
        if (bus.dbg_dout !== exp_same) begin
            miscompares++;
            $display("FAIL byp_dbg: got %h want %h", bus.dbg_dout, exp_same);
        end
        @(posedge clk);
        #1;
        bus.we = 1'b0;
        v = bus.dout[31:0];
        vectors++;
        if (v !== 32'h0000_0055) begin
            miscompares++;
            $display("FAIL byp_after_edge: got %h want %h", v, 32'h0000_0055);
        end
        @(negedge clk);
        bus.we = 1'b1; bus.wa = 5'd0; bus.din = 32'h0000_0077;
        rd1(5'd0, v);
        vectors++;
        if (v !== 32'h0) begin
            miscompares++;
            $display("FAIL byp_r0: got %h want %h", v, 32'h0);
        end
        @(negedge clk);
        bus.we = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        pulse(1'b1, 1'b0);
        wr(5'd10, 32'h0000_0042);
        @(negedge clk);
        bus.we = 1'b1; bus.wa = 5'd10; bus.din = 32'h0000_0077;
        bus.int_entry = 1'b1;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (bus.bank !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst_async_bank: got %b want 0", bus.bank);
        end
        bus.we = 1'b0;
        bus.int_entry = 1'b0;
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (bus.bank !== 1'b0 || bus.bank_err !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rst_bank: got bank=%b err=%b want 0 0", bus.bank, bus.bank_err);
        end
        pulse(1'b1, 1'b0);
        rd0(5'd10, v);
        vectors++;
        if (v !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_rst_discard: got %h want %h", v, 32'h0);
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b0;
        bus.we = 1'b0;
        bus.wa = '0;
        bus.din = '0;
        bus.ra = '0;
        bus.int_entry = 1'b0;
        bus.eret = 1'b0;
        bus.dbg_ra = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_write_read();
        test_shared_gp();
        test_zero();
        test_back_to_back();
        test_boundary();
        test_bypass();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
